// File: rtl/alu_op_scheduler_if.sv
// Requester, ALU and response channels of the ALU op scheduler.
// The scheduler uses the slave modport; requesters, ALU and consumer use master.
interface alu_op_scheduler_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_inst;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_inst;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [3:0]       alu_inst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_firstcyc;
  logic [WIDTH-1:0] alu_z;
  logic [3:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_z;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_inst, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_inst, req1_a, req1_b,
    output req1_ready,
    output alu_inst, alu_a, alu_b, alu_firstcyc,
    input  alu_z, alu_flags,
    output rsp_valid, rsp_id, rsp_z, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_inst, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_inst, req1_a, req1_b,
    input  req1_ready,
    input  alu_inst, alu_a, alu_b, alu_firstcyc,
    output alu_z, alu_flags,
    input  rsp_valid, rsp_id, rsp_z, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Round-robin front end for a shared ALU: accepts one op at a time, drives the ALU
// for ALU_LAT cycles, then returns the captured result on a tagged response channel.
module alu_op_scheduler #(
  parameter int         WIDTH     = 32,
  parameter int         ALU_LAT   = 1,
  parameter logic [3:0] IDLE_INST = 4'b1110
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_op_scheduler_if.slave bus_io
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] UNDEF_INST = 4'b0110;
  localparam logic [3:0] LAT        = 4'(ALU_LAT);

  logic [1:0]       state_q, state_d;
  logic             rrPtr_q, rrPtr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       aluInst_q, aluInst_d;
  logic [WIDTH-1:0] aluA_q, aluA_d;
  logic [WIDTH-1:0] aluB_q, aluB_d;
  logic             firstCyc_q, firstCyc_d;
  logic             rspId_q, rspId_d;
  logic [WIDTH-1:0] rspZ_q, rspZ_d;
  logic [3:0]       rspFlags_q, rspFlags_d;
  logic             rspErr_q, rspErr_d;

  logic             grant1;
  logic             ready0;
  logic             ready1;
  logic             accept;
  logic [3:0]       selInst;
  logic [WIDTH-1:0] selA;
  logic [WIDTH-1:0] selB;

  // Requester 1 wins when it is alone or when the pointer favours it under contention.
  always_comb begin
    grant1  = bus_io.req1_valid & (~bus_io.req0_valid | rrPtr_q);
    ready0  = ~rst_i & (state_q == IDLE) & bus_io.req0_valid & ~grant1;
    ready1  = ~rst_i & (state_q == IDLE) & grant1;
    accept  = ready0 | ready1;
    selInst = grant1 ? bus_io.req1_inst : bus_io.req0_inst;
    selA    = grant1 ? bus_io.req1_a    : bus_io.req0_a;
    selB    = grant1 ? bus_io.req1_b    : bus_io.req0_b;
  end

  assign bus_io.req0_ready   = ready0;
  assign bus_io.req1_ready   = ready1;
  assign bus_io.alu_inst     = aluInst_q;
  assign bus_io.alu_a        = aluA_q;
  assign bus_io.alu_b        = aluB_q;
  assign bus_io.alu_firstcyc = firstCyc_q;
  assign bus_io.rsp_valid    = (state_q == RESP);
  assign bus_io.rsp_id       = rspId_q;
  assign bus_io.rsp_z        = rspZ_q;
  assign bus_io.rsp_flags    = rspFlags_q;
  assign bus_io.rsp_err      = rspErr_q;

  // The ALU drive registers double as the op registers, so operands never toggle while idle.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    cnt_d      = cnt_q;
    aluInst_d  = aluInst_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    firstCyc_d = firstCyc_q;
    rspId_d    = rspId_q;
    rspZ_d     = rspZ_q;
    rspFlags_d = rspFlags_q;
    rspErr_d   = rspErr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rspId_d = grant1;
          rrPtr_d = ~grant1;
          if (selInst == UNDEF_INST) begin
            state_d    = RESP;
            rspZ_d     = '0;
            rspFlags_d = 4'h0;
            rspErr_d   = 1'b1;
          end else begin
            state_d    = EXEC;
            cnt_d      = LAT;
            aluInst_d  = selInst;
            aluA_d     = selA;
            aluB_d     = selB;
            firstCyc_d = 1'b1;
          end
        end
      end
      EXEC: begin
        firstCyc_d = 1'b0;
        cnt_d      = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          aluInst_d  = IDLE_INST;
          rspZ_d     = bus_io.alu_z;
          rspFlags_d = bus_io.alu_flags;
          rspErr_d   = 1'b0;
        end
      end
      RESP: begin
        if (bus_io.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rrPtr_q    <= 1'b0;
      cnt_q      <= 4'd0;
      aluInst_q  <= IDLE_INST;
      aluA_q     <= '0;
      aluB_q     <= '0;
      firstCyc_q <= 1'b0;
      rspId_q    <= 1'b0;
      rspZ_q     <= '0;
      rspFlags_q <= 4'h0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      cnt_q      <= cnt_d;
      aluInst_q  <= aluInst_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      firstCyc_q <= firstCyc_d;
      rspId_q    <= rspId_d;
      rspZ_q     <= rspZ_d;
      rspFlags_q <= rspFlags_d;
      rspErr_q   <= rspErr_d;
    end
  end
endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Front-end sequencer for the 32-bit ALU datapath; the ALU is shared by two independent requesters.
- Arbitrates round-robin, latches the winning operation, and drives INST/A/B/FirstCyc to the ALU for a fixed latency.
- Captures Z and FLAGS, then returns them on a valid/ready response channel tagged with the requester ID.
- While idle, parks the ALU on a logic-class constant instruction so the gated adder input registers do not clock.

Parameters:
- WIDTH, 32, operand and result width.
- ALU_LAT, 1, ALU cycles from operand launch to Z/FLAGS valid (legal range 1..15).
- IDLE_INST, 4'b1110, instruction driven to the ALU when no op is in flight (i_0, logic class).

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ0_VALID  input  1  requester 0 has an op.
- REQ0_READY  output  1  requester 0 op accepted this cycle.
- REQ0_INST  input  4  requester 0 ALU opcode.
- REQ0_A  input  WIDTH  requester 0 operand A.
- REQ0_B  input  WIDTH  requester 0 operand B.
- REQ1_VALID, REQ1_READY, REQ1_INST, REQ1_A, REQ1_B: same as requester 0, for requester 1.
- ALU_INST  output  4  opcode to ALU.
- ALU_A  output  WIDTH  operand A to ALU.
- ALU_B  output  WIDTH  operand B to ALU.
- ALU_FIRSTCYC  output  1  first execute cycle marker.
- ALU_Z  input  WIDTH  ALU result.
- ALU_FLAGS  input  4  ALU flags.
- RSP_VALID  output  1  response available.
- RSP_READY  input  1  consumer takes response.
- RSP_ID  output  1  requester that issued the op.
- RSP_Z  output  WIDTH  captured result.
- RSP_FLAGS  output  4  captured flags.
- RSP_ERR  output  1  op used an undefined opcode.

Behaviour:
- Reset values: ALU_INST=IDLE_INST, ALU_A/ALU_B=0, ALU_FIRSTCYC=0, RSP_VALID=0, RSP_ID=0, RSP_Z=0, RSP_FLAGS=0, RSP_ERR=0, both READY=0, state=IDLE, rr pointer=0 (requester 0 favoured), exec counter=0.
- Reset mid-operation: the in-flight op and any pending response are discarded; no response is ever produced for them.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant:
  - Only one requester valid: grant it.
  - Both valid: grant the requester the rr pointer favours.
  - REQx_READY = (state==IDLE) and grant==x. It is combinational from VALID and state; at most one READY is high per cycle.
- IDLE, on accept (VALID&READY):
  - Latch INST, A and B into the op registers and the requester number into the ID register.
  - Set the rr pointer to the other requester.
  - Defined opcode: go to EXEC with counter=ALU_LAT.
  - Undefined opcode (4'b0110): go directly to RESP with RSP_Z=0, RSP_FLAGS=0, RSP_ERR=1; the ALU is never driven with it.
- IDLE, no accept: ALU_INST=IDLE_INST; ALU_A/ALU_B hold their last values (no toggling).
- EXEC:
  - ALU_INST/ALU_A/ALU_B come from the op registers and are stable for every EXEC cycle.
  - ALU_FIRSTCYC=1 in the first EXEC cycle only.
  - The counter decrements each cycle. In the cycle where counter==1, ALU_Z/ALU_FLAGS are sampled on the closing edge into RSP_Z/RSP_FLAGS, RSP_ERR=0, and the FSM moves to RESP.
- EXEC, ALU drive on exit: ALU_INST returns to IDLE_INST on the same edge the FSM leaves EXEC.
- RESP:
  - RSP_VALID=1; RSP_ID/RSP_Z/RSP_FLAGS/RSP_ERR are held stable until the handshake.
  - On RSP_READY, go to IDLE. RSP_VALID drops on the next edge.
  - No requester is accepted in RESP.
- Latency: accept at edge E; EXEC occupies cycles E+1..E+ALU_LAT; RSP_VALID is high from E+ALU_LAT+1. Minimum cycles from accept to next accept = ALU_LAT+2 with RSP_READY held high.
- Requester VALID may drop without an accept; there is no penalty and no state change.
- REQ inputs changing while not accepted are ignored.
- RSP_READY high outside RESP is ignored.

Test Plan:
- Single op: REQ0 add_ab A=5 B=7, ALU_LAT=1, RSP_READY=1.
  - REQ0_READY pulses 1 cycle.
  - ALU_INST=0010 and FIRSTCYC=1 for 1 cycle.
  - RSP_VALID 2 cycles after accept with RSP_Z=12, RSP_ID=0, RSP_ERR=0.
- Contention: both requesters valid continuously with distinct ops.
  - Grants alternate 0,1,0,1.
  - Four responses appear in that order with matching IDs and results.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID.
  - RSP fields stay constant and both READYs stay 0.
  - After RSP_READY=1, the next grant occurs in the following IDLE cycle.
- Latency: ALU_LAT=3, sub_ab A=10 B=3.
  - ALU_A/ALU_B/ALU_INST are held for 3 cycles and FIRSTCYC is only in the first.
  - RSP_Z=7, RSP_VALID at accept+4.
- Undefined opcode 0110 from REQ1.
  - ALU_INST stays at IDLE_INST.
  - RSP_VALID at accept+1 with RSP_ERR=1, RSP_Z=0, RSP_ID=1.
- Assert RESET during EXEC.
  - All outputs return to reset values asynchronously.
  - No response appears after release; the next request is granted to requester 0.
